// File: rtl/scc_wave_reader.sv
// scc_wave_reader: time-multiplexed wave-table sequencer for the SCC channels.
// One channel is serviced per enable tick in round-robin order: its frequency
// down-counter and phase pointer are stepped, the wave SRAM is read at
// {ch, phase}, and the signed sample is presented with its channel index.
// Optional build macro: SCC_FREQ_PHASE_RESET_EN -- a valid frequency write also
// restarts the channel (phase cleared, counter loaded with the new frequency).
module scc_wave_reader #(
  parameter int CH_NUM = 5,
  parameter int FREQ_W = 12
) (
  input  logic              nreset,
  input  logic              clk,
  input  logic              enable,
  input  logic              reg_freq_wr,
  input  logic [2:0]        reg_ch,
  input  logic [FREQ_W-1:0] reg_freq,
  input  logic [4:0]        reg_key_on,
  output logic [7:0]        sram_a,
  output logic              sram_rd,
  input  logic [7:0]        sram_q,
  output logic [7:0]        sample,
  output logic [2:0]        sample_ch,
  output logic              sample_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic [2:0] LAST_CH = 3'(CH_NUM - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_slot;
  logic [2:0]        r_ch;
  logic              r_pending;

  logic [FREQ_W-1:0] r_freq  [CH_NUM];
  logic [FREQ_W-1:0] r_cnt   [CH_NUM];
  logic [4:0]        r_phase [CH_NUM];

  logic [7:0]        r_sram_a;
  logic              r_sram_rd;
  logic [7:0]        r_sample;
  logic [2:0]        r_sample_ch;
  logic              r_sample_valid;

  logic [FREQ_W-1:0] w_cnt_cur;
  logic [FREQ_W-1:0] w_freq_cur;
  logic [4:0]        w_phase_cur;
  logic              w_cnt_zero;
  logic [4:0]        w_phase_next;
  logic              w_key_on;
  logic              w_wr_ok;

  // Select the serviced channel's state and decide whether its phase steps.
  always_comb begin
    w_cnt_cur   = r_cnt[r_ch];
    w_freq_cur  = r_freq[r_ch];
    w_phase_cur = r_phase[r_ch];
    w_key_on    = reg_key_on[r_ch];
    w_wr_ok     = reg_freq_wr & (reg_ch <= LAST_CH);
    w_cnt_zero  = (w_cnt_cur == {FREQ_W{1'b0}});
    if (w_cnt_zero) begin
      w_phase_next = w_phase_cur + 5'd1;
    end else begin
      w_phase_next = w_phase_cur;
    end
  end

  // Per-channel frequency, counter and phase; a register write is applied
  // after the COUNT update so that, when both hit the same channel on the
  // same edge, COUNT has already consumed the old frequency.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_freq[i]  <= {FREQ_W{1'b0}};
        r_cnt[i]   <= {FREQ_W{1'b0}};
        r_phase[i] <= 5'd0;
      end
    end else begin
      if (r_state == ST_COUNT) begin
        if (w_cnt_zero) begin
          r_cnt[r_ch] <= w_freq_cur;
        end else begin
          r_cnt[r_ch] <= w_cnt_cur - {{(FREQ_W-1){1'b0}}, 1'b1};
        end
        r_phase[r_ch] <= w_phase_next;
      end
      if (w_wr_ok) begin
        r_freq[reg_ch] <= reg_freq;
`ifdef SCC_FREQ_PHASE_RESET_EN
        r_phase[reg_ch] <= 5'd0;
        r_cnt[reg_ch]   <= reg_freq;
`endif
      end
    end
  end

  // Service sequencer: IDLE -> COUNT -> READ -> WAIT, with a one-deep
  // pending flag that remembers an enable arriving mid-service.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state        <= ST_IDLE;
      r_slot         <= 3'd0;
      r_ch           <= 3'd0;
      r_pending      <= 1'b0;
      r_sram_a       <= 8'd0;
      r_sram_rd      <= 1'b0;
      r_sample       <= 8'd0;
      r_sample_ch    <= 3'd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if ((r_state != ST_IDLE) && enable) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable | r_pending) begin
            r_state   <= ST_COUNT;
            r_ch      <= r_slot;
            r_pending <= 1'b0;
          end
        end
        ST_COUNT: begin
          r_sram_a  <= {r_ch, w_phase_next};
          r_sram_rd <= w_key_on;
          r_state   <= ST_READ;
        end
        ST_READ: begin
          r_sram_rd <= 1'b0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          r_sample       <= w_key_on ? sram_q : 8'd0;
          r_sample_ch    <= r_ch;
          r_sample_valid <= 1'b1;
          r_slot         <= (r_slot == LAST_CH) ? 3'd0 : r_slot + 3'd1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_a       = r_sram_a;
  assign sram_rd      = r_sram_rd;
  assign sample       = r_sample;
  assign sample_ch    = r_sample_ch;
  assign sample_valid = r_sample_valid;

endmodule
